// File: rtl/xpb_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : xpb_accumulator_if
//  Description : Handshake bundle between the xpb ROM stream, the
//                accumulator and the consumer of the resolved sum.
//                  start     - begin a new accumulation
//                  xpb_valid - xpb_data carries a term this cycle
//                  xpb_data  - DATA_W-bit term from the xpb ROM
//                  xpb_ready - accumulator accepts a term this cycle
//                  sum_valid - sum_data holds the final total
//                  sum_data  - OUT_W-bit resolved sum
//                  sum_ready - consumer accepts sum_data
//                  busy      - accumulator is not idle
//                master = stream/consumer side, slave = accumulator side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xpb_accumulator_if #(
   parameter int DATA_W    = 1024,
   parameter int NUM_TERMS = 8
);
   localparam int OUT_W = DATA_W + $clog2(NUM_TERMS);

   logic              start;
   logic              xpb_valid;
   logic [DATA_W-1:0] xpb_data;
   logic              xpb_ready;
   logic              sum_valid;
   logic [OUT_W-1:0]  sum_data;
   logic              sum_ready;
   logic              busy;

   modport master (
      output start, xpb_valid, xpb_data, sum_ready,
      input  xpb_ready, sum_valid, sum_data, busy
   );

   modport slave (
      input  start, xpb_valid, xpb_data, sum_ready,
      output xpb_ready, sum_valid, sum_data, busy
   );
endinterface
`default_nettype wire

// File: rtl/xpb_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : xpb_accumulator
//  Description : Sums NUM_TERMS xpb lookup-table words into one unreduced
//                total. Terms are folded into a carry-save pair (S, C) one
//                per cycle; the pair is then resolved by a carry-propagate
//                adder working SEG_W bits per cycle, LSB segment first.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous active-high reset
//                bus   - xpb_accumulator_if.slave (term stream in, sum out)
//  Revision    : 1.0 - initial release
// ============================================================================
module xpb_accumulator #(
   parameter int DATA_W    = 1024,
   parameter int NUM_TERMS = 8,
   parameter int SEG_W     = 64
) (
   input logic              clk,
   input logic              reset,
   xpb_accumulator_if.slave bus
);
   localparam int c_OUT_W     = DATA_W + $clog2(NUM_TERMS);
   localparam int c_NSEG      = (c_OUT_W + SEG_W - 1) / SEG_W;
   localparam int c_TOP_W     = c_OUT_W - (c_NSEG - 1) * SEG_W;
   localparam int c_CNT_W     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
   localparam int c_SEG_IDX_W = (c_NSEG > 1) ? $clog2(c_NSEG) : 1;

   localparam logic [c_CNT_W-1:0]     c_LAST_CNT = c_CNT_W'(NUM_TERMS - 1);
   localparam logic [c_SEG_IDX_W-1:0] c_LAST_SEG = c_SEG_IDX_W'(c_NSEG - 1);

   localparam logic [1:0] c_ST_IDLE    = 2'd0;
   localparam logic [1:0] c_ST_ACCUM   = 2'd1;
   localparam logic [1:0] c_ST_RESOLVE = 2'd2;
   localparam logic [1:0] c_ST_DONE    = 2'd3;

   logic [1:0]             r_state;
   logic [1:0]             w_state_next;
   logic [c_OUT_W-1:0]     r_s;
   // Carry vector stored already shifted left by one (holds C<<1), so the
   // shifted-out MSB of C never needs a flop.
   logic [c_OUT_W-1:0]     r_c2;
   logic [c_CNT_W-1:0]     r_cnt;
   logic [c_SEG_IDX_W-1:0] r_seg;
   logic                   r_carry;
   logic [c_OUT_W-1:0]     r_sum;

   logic [c_OUT_W-1:0]     w_term;
   logic [c_OUT_W-1:0]     w_csa_s;
   logic [c_OUT_W-2:0]     w_csa_c;
   logic                   w_accept;
   logic                   w_last_term;
   logic                   w_last_seg;
   logic [SEG_W-1:0]       w_seg_s;
   logic [SEG_W-1:0]       w_seg_c;
   logic [SEG_W:0]         w_seg_add;

   wire  [SEG_W-1:0]       w_seg_s_arr [c_NSEG];
   wire  [SEG_W-1:0]       w_seg_c_arr [c_NSEG];
   wire  [c_OUT_W-1:0]     w_sum_next;

   assign w_accept    = bus.xpb_valid && (r_state == c_ST_ACCUM);
   assign w_last_term = (r_cnt == c_LAST_CNT);
   assign w_last_seg  = (r_seg == c_LAST_SEG);

   // 3:2 compressor over S, C<<1 and the zero-extended term
   assign w_term  = c_OUT_W'(bus.xpb_data);
   assign w_csa_s = r_s ^ r_c2 ^ w_term;
   assign w_csa_c = (r_s[c_OUT_W-2:0]  & r_c2[c_OUT_W-2:0])
                  | (r_s[c_OUT_W-2:0]  & w_term[c_OUT_W-2:0])
                  | (r_c2[c_OUT_W-2:0] & w_term[c_OUT_W-2:0]);

   // Per-segment operand slices (top segment zero-padded to SEG_W) and the
   // merge of the freshly resolved segment into the running result.
   for (genvar g = 0; g < c_NSEG; g++) begin : g_seg
      localparam int c_W = (g == c_NSEG - 1) ? c_TOP_W : SEG_W;
      assign w_seg_s_arr[g] = SEG_W'(r_s[g*SEG_W +: c_W]);
      assign w_seg_c_arr[g] = SEG_W'(r_c2[g*SEG_W +: c_W]);
      assign w_sum_next[g*SEG_W +: c_W] = (r_seg == c_SEG_IDX_W'(g))
                                        ? w_seg_add[c_W-1:0]
                                        : r_sum[g*SEG_W +: c_W];
   end

   assign w_seg_s   = w_seg_s_arr[r_seg];
   assign w_seg_c   = w_seg_c_arr[r_seg];
   assign w_seg_add = {1'b0, w_seg_s} + {1'b0, w_seg_c} + {{SEG_W{1'b0}}, r_carry};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_ST_IDLE:    if (bus.start)                 w_state_next = c_ST_ACCUM;
         c_ST_ACCUM:   if (w_accept && w_last_term)   w_state_next = c_ST_RESOLVE;
         c_ST_RESOLVE: if (w_last_seg)                w_state_next = c_ST_DONE;
         c_ST_DONE:    if (bus.sum_ready)             w_state_next = c_ST_IDLE;
         default:                                     w_state_next = c_ST_IDLE;
      endcase
   end

   always_comb begin
      bus.xpb_ready = (r_state == c_ST_ACCUM);
      bus.sum_valid = (r_state == c_ST_DONE);
      bus.busy      = (r_state != c_ST_IDLE);
   end

   assign bus.sum_data = r_sum;

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s     <= '0;
         r_c2    <= '0;
         r_cnt   <= '0;
         r_seg   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (bus.start) begin
                  r_s   <= '0;
                  r_c2  <= '0;
                  r_cnt <= '0;
               end
            end
            c_ST_ACCUM: begin
               if (w_accept) begin
                  r_s   <= w_csa_s;
                  r_c2  <= {w_csa_c, 1'b0};
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last_term) begin
                     r_seg   <= '0;
                     r_carry <= 1'b0;
                  end
               end
            end
            c_ST_RESOLVE: begin
               // Carry out of the top segment is provably zero and simply
               // left behind in r_carry.
               r_sum   <= w_sum_next;
               r_carry <= w_seg_add[SEG_W];
               r_seg   <= r_seg + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire
